alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute-stage ALU; consumes 5-bit aluOp from the ALU-control decoder plus two operands.
//  Produces a registered result, destination tag and branch-compare flags under valid/ready handshake.
//  Sits between operand fetch/forwarding and writeback/branch-resolve logic.
// PARAMETERS
//  XLEN   32  operand/result width (power of 2); localparam SHW = $clog2(XLEN)
//  TAG_W  5   width of pass-through tag (destination register index)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      operation presented
//  in_ready    out  1      block can accept; transfer when in_valid && in_ready
//  in_alu_op   in   5      [4]=use ALU, [3]=alt (sub/sra), [2:0]=funct3
//  in_a        in   XLEN   operand A (rs1)
//  in_b        in   XLEN   operand B (rs2 or immediate)
//  in_tag      in   TAG_W  carried unchanged to out_tag
//  out_valid   out  1      result held; transfer when out_valid && out_ready
//  out_ready   in   1      downstream accepts
//  out_result  out  XLEN   ALU result
//  out_tag     out  TAG_W  tag of this result
//  out_eq      out  1      in_a == in_b
//  out_lt      out  1      $signed(in_a) < $signed(in_b)
//  out_ltu     out  1      in_a < in_b unsigned
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, out_tag=0, out_eq/lt/ltu=0, FSM=IDLE, shift counter=0.
//  op[4]=0 -> result=in_b (op[3:0] ignored). op[4]=1, by op[2:0]:
//   000 add (op[3]=1: sub), 001 sll, 010 slt (signed, 1/0), 011 sltu, 100 xor,
//   101 srl (op[3]=1: sra), 110 or, 111 and. op[3] ignored for 001,010,011,100,110,111.
//  Shift amount = in_b[SHW-1:0]; upper B bits ignored. Add/sub wrap modulo 2^XLEN.
//  Flags computed from operands regardless of op; registered with result.
//  Output register: 1 entry. in_ready = (FSM==IDLE) && (!out_valid || out_ready).
//  Latency 1: accept on edge N -> out_valid=1 and outputs valid after edge N.
//  out_* stable while out_valid && !out_ready. Accept and drain on same edge: new data replaces, out_valid stays 1.
//  out_valid drops after edge where out_ready=1 and no new accept.
//  in_* values ignored when not transferring; no combinational in->out path.
//  Async reset mid-operation aborts any in-flight op; no result emitted.
// CONFIGURATION
//  ALU_SERIAL_SHIFT_EN defined: shifts (op 1_x001, 1_x101) use 1-bit/cycle shifter, not barrel.
//   FSM IDLE->SHIFT on accept when shamt!=0; work reg<=in_a, cnt<=shamt; flags/tag captured at accept.
//   SHIFT: each edge shifts work reg 1 bit (sra replicates sign), cnt--;
//   edge with cnt==1 writes out_result, sets out_valid, FSM->IDLE.
//   Shift latency = max(1,shamt) cycles; shamt=0 behaves as 1-cycle op.
//   in_ready=0 throughout SHIFT. out_ready has no effect on an op in progress.
//  Not defined: single-cycle barrel shifter, FSM absent, in_ready = !out_valid || out_ready.
//  Results identical in both builds; only timing differs.
// TESTING
//  1 reset: rst_n=0 mid-stream -> out_valid=0, out_result=0 same cycle, in_ready=1 after release.
//  2 op=11000 a=5 b=7 -> out_result=32'hFFFF_FFFE, out_lt=1, out_ltu=1, out_eq=0, 1 cycle.
//  3 op=11101 a=32'h8000_0000 b=4 -> 32'hF800_0000; op=10101 same -> 32'h0800_0000;
//    with ALU_SERIAL_SHIFT_EN out_valid after exactly 4 edges, in_ready=0 for those 4 cycles.
//  4 op=00xxx a=3 b=9 -> out_result=9; op=10010 a=-1 b=1 -> 1; op=10011 a=-1 b=1 -> 0.
//  5 back-pressure: out_ready=0 for 3 cycles, 2nd op offered -> in_ready=0, first result stable;
//    out_ready=1 -> 2nd accepted same edge, results in order, tags 3 then 7 preserved.
//  6 streaming: in_valid=out_ready=1, 8 add ops -> 1 result/cycle, no bubbles, no drops.

Source files
------------

// File: rtl/alu_exec.sv
// Execute-stage ALU with a one-entry registered output and valid/ready handshakes.
// Define ALU_SERIAL_SHIFT_EN to use a 1-bit/cycle shifter FSM instead of a barrel shifter.
module alu_exec #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_alu_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_eq,
   output logic             out_lt,
   output logic             out_ltu
);

   localparam int SHW = $clog2(XLEN);

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic             w_eq;
   logic             w_lt;
   logic             w_ltu;
   logic [XLEN-1:0]  w_result;

   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_result;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_eq;
   logic             r_out_lt;
   logic             r_out_ltu;

`ifdef ALU_SERIAL_SHIFT_EN
   localparam logic [0:0]     ST_IDLE  = 1'b0;
   localparam logic [0:0]     ST_SHIFT = 1'b1;
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

   logic [0:0]      r_state;
   logic [XLEN-1:0] r_work;
   logic [SHW-1:0]  r_cnt;
   logic            r_left;
   logic            r_arith;
   logic            w_is_shift;
   logic [XLEN-1:0] w_step;

   assign w_is_shift = in_alu_op[4] && (in_alu_op[1:0] == 2'b01);
   assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);

   always_comb begin
      w_step = r_work;
      if (r_left)
         w_step = {r_work[XLEN-2:0], 1'b0};
      else
         w_step = {(r_arith & r_work[XLEN-1]), r_work[XLEN-1:1]};
   end
`else
   assign in_ready = !r_out_valid || out_ready;
`endif

   assign w_accept = in_valid && in_ready;
   assign w_shamt  = in_b[SHW-1:0];
   assign w_eq     = (in_a == in_b);
   assign w_lt     = ($signed(in_a) < $signed(in_b));
   assign w_ltu    = (in_a < in_b);

   always_comb begin
      w_result = in_b;
      if (in_alu_op[4]) begin
         case (in_alu_op[2:0])
            3'b000: w_result = in_alu_op[3] ? (in_a - in_b) : (in_a + in_b);
`ifdef ALU_SERIAL_SHIFT_EN
            // Only reached for shamt==0; nonzero shifts go through the FSM.
            3'b001: w_result = in_a;
            3'b101: w_result = in_a;
`else
            3'b001: w_result = in_a << w_shamt;
            3'b101: w_result = in_alu_op[3] ? $unsigned($signed(in_a) >>> w_shamt)
                                            : (in_a >> w_shamt);
`endif
            3'b010: w_result = {{(XLEN-1){1'b0}}, w_lt};
            3'b011: w_result = {{(XLEN-1){1'b0}}, w_ltu};
            3'b100: w_result = in_a ^ in_b;
            3'b110: w_result = in_a | in_b;
            3'b111: w_result = in_a & in_b;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_tag    <= '0;
         r_out_eq     <= 1'b0;
         r_out_lt     <= 1'b0;
         r_out_ltu    <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
         r_state      <= ST_IDLE;
         r_work       <= '0;
         r_cnt        <= '0;
         r_left       <= 1'b0;
         r_arith      <= 1'b0;
`endif
      end else begin
`ifdef ALU_SERIAL_SHIFT_EN
         if (r_state == ST_SHIFT) begin
            r_work <= w_step;
            r_cnt  <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
               r_out_result <= w_step;
               r_out_valid  <= 1'b1;
               r_state      <= ST_IDLE;
            end
         end else
`endif
         if (w_accept) begin
            r_out_tag <= in_tag;
            r_out_eq  <= w_eq;
            r_out_lt  <= w_lt;
            r_out_ltu <= w_ltu;
`ifdef ALU_SERIAL_SHIFT_EN
            // Tag/flags land now; result and valid follow when the count expires.
            if (w_is_shift && (w_shamt != '0)) begin
               r_state     <= ST_SHIFT;
               r_work      <= in_a;
               r_cnt       <= w_shamt;
               r_left      <= ~in_alu_op[2];
               r_arith     <= in_alu_op[3];
               r_out_valid <= 1'b0;
            end else
`endif
            begin
               r_out_result <= w_result;
               r_out_valid  <= 1'b1;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_tag    = r_out_tag;
   assign out_eq     = r_out_eq;
   assign out_lt     = r_out_lt;
   assign out_ltu    = r_out_ltu;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; honours ALU_SERIAL_SHIFT_EN timing when defined.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_alu_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        out_eq;
   logic        out_lt;
   logic        out_ltu;

   int errors = 0;
   int checks = 0;

   alu_exec #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_eq(out_eq), .out_lt(out_lt), .out_ltu(out_ltu)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      in_valid  = 1'b1;
      in_alu_op = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
   endtask

   task automatic test_reset();
      logic stayed_low;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_alu_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      repeat (2) step();
      checks++;
      if ({out_valid, out_result, out_tag, out_eq, out_lt, out_ltu} !== 41'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b res=%h tag=%h flags=%b%b%b, want all zero",
                  out_valid, out_result, out_tag, out_eq, out_lt, out_ltu);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
      end
      offer(5'b11101, 32'h8000_0000, 32'd4, 5'd5);
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: valid=%b res=%h want 0/00000000", out_valid, out_result);
      end
      step();
      rst_n = 1'b1;
      stayed_low = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (out_valid !== 1'b0) stayed_low = 1'b0;
      end
      checks++;
      if (stayed_low !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_abort: stayed_low=%b in_ready=%b want 1/1", stayed_low, in_ready);
      end
   endtask

   task automatic test_add_sub();
      out_ready = 1'b1;
      offer(5'b11000, 32'd5, 32'd7, 5'd1);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE || out_tag !== 5'd1) begin
         errors++;
         $display("FAIL sub: valid=%b res=%h tag=%0d want 1/fffffffe/1", out_valid, out_result, out_tag);
      end
      checks++;
      if ({out_eq, out_lt, out_ltu} !== 3'b011) begin
         errors++; $display("FAIL sub_flags: eq/lt/ltu=%b%b%b want 011", out_eq, out_lt, out_ltu);
      end
      offer(5'b10000, 32'hFFFF_FFFF, 32'd1, 5'd2);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_result !== 32'd0 || {out_eq, out_lt, out_ltu} !== 3'b010) begin
         errors++;
         $display("FAIL add_wrap: res=%h flags=%b%b%b want 00000000/010", out_result, out_eq, out_lt, out_ltu);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_shift();
      logic [4:0]  ops [2]  = '{5'b11101, 5'b10101};
      logic [31:0] exps [2] = '{32'hF800_0000, 32'h0800_0000};
      logic        busy_ok;
      out_ready = 1'b1;
      for (int s = 0; s < 2; s++) begin
         offer(ops[s], 32'h8000_0000, 32'hFFFF_FFE4, 5'd9);
         step();
         in_valid = 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
         busy_ok = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
            if (k < 3) step();
         end
         checks++;
         if (busy_ok !== 1'b1) begin
            errors++; $display("FAIL shift_busy[%0d]: busy_ok=%b want 1", s, busy_ok);
         end
         step();
`else
         busy_ok = 1'b1;
`endif
         checks++;
         if (out_valid !== 1'b1 || out_result !== exps[s] || out_tag !== 5'd9) begin
            errors++;
            $display("FAIL shift[%0d]: valid=%b res=%h tag=%0d want 1/%h/9", s, out_valid, out_result, out_tag, exps[s]);
         end
         checks++;
         if ({out_eq, out_lt, out_ltu} !== 3'b011) begin
            errors++; $display("FAIL shift_flags[%0d]: %b%b%b want 011", s, out_eq, out_lt, out_ltu);
         end
         step();
      end
      offer(5'b10001, 32'd1, 32'd31, 5'd4);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 40 && out_valid !== 1'b1; k++) step();
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin
         errors++; $display("FAIL sll31: valid=%b res=%h want 1/80000000", out_valid, out_result);
      end
      step();
      offer(5'b11101, 32'h8000_0010, 32'd0, 5'd6);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h8000_0010) begin
         errors++; $display("FAIL shamt0: valid=%b res=%h want 1/80000010", out_valid, out_result);
      end
      step();
   endtask

   task automatic test_logic_pass();
      logic [4:0]  ops  [7] = '{5'b00111, 5'b10010, 5'b10011, 5'b10100, 5'b11100, 5'b10110, 5'b10111};
      logic [31:0] as   [7] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hF0F0};
      logic [31:0] bs   [7] = '{32'd9, 32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00, 32'hFF00};
      logic [31:0] exps [7] = '{32'd9, 32'd1, 32'd0, 32'h0FF0, 32'h0FF0, 32'hFFF0, 32'hF000};
      out_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         offer(ops[v], as[v], bs[v], 5'(v));
         step();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_result !== exps[v]) begin
            errors++;
            $display("FAIL op_vec[%0d]: valid=%b res=%h want 1/%h", v, out_valid, out_result, exps[v]);
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      logic held_ok;
      out_ready = 1'b0;
      offer(5'b11000, 32'd10, 32'd3, 5'd3);
      step();
      offer(5'b10000, 32'd20, 32'd22, 5'd7);
      held_ok = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd7 || out_tag !== 5'd3)
            held_ok = 1'b0;
         step();
      end
      checks++;
      if (held_ok !== 1'b1) begin
         errors++; $display("FAIL bp_hold: held_ok=%b want 1", held_ok);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: in_ready=%b want 1", in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd42 || out_tag !== 5'd7) begin
         errors++;
         $display("FAIL bp_second: valid=%b res=%0d tag=%0d want 1/42/7", out_valid, out_result, out_tag);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic stream_ok;
      out_ready = 1'b1;
      stream_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (in_ready !== 1'b1) stream_ok = 1'b0;
         offer(5'b10000, 32'(i), 32'(100 * i), 5'(i + 10));
         step();
         if (out_valid !== 1'b1 || out_result !== 32'(101 * i) || out_tag !== 5'(i + 10))
            stream_ok = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (stream_ok !== 1'b1) begin
         errors++; $display("FAIL stream: stream_ok=%b want 1", stream_ok);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_end: out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_logic_pass();
      test_backpressure();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
